vid_scanout: RTL and testbench

Downstream scanout stage of the video controller. Buffers the RGB words that the fetch logic reads over the bus in a pixel FIFO, then generates horizontal and vertical timing from the programmed `cr`/`h1`/`h2`/`v1`/`v2` fields. It pops one pixel per pixel-clock tick during the active region and drives `hsync`/`hblank`/`vsync`/`vblank`/`R`/`G`/`B` to the display.

---
 rtl/vid_pkg.sv | 44 ++++
 rtl/vid_pix_fifo.sv | 52 +++++
 rtl/vid_scanout.sv | 215 +++++++++++++++++++++
 tb/tb_vid_scanout.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types for the video scanout path: register field structs, scanout states, counter width.
package vid_pkg;

  localparam int VID_CW = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [5:0] pcnt;
    logic       en;
  } cr_t;

  typedef struct packed {
    logic [VID_CW-1:0] hend;
    logic [VID_CW-1:0] hsize;
  } h1_t;

  typedef struct packed {
    logic [VID_CW-1:0] hsync_end;
    logic [VID_CW-1:0] hsync_start;
  } h2_t;

  typedef struct packed {
    logic [VID_CW-1:0] vend;
    logic [VID_CW-1:0] vsize;
  } v1_t;

  typedef struct packed {
    logic [VID_CW-1:0] vsync_end;
    logic [VID_CW-1:0] vsync_start;
  } v2_t;

  // Half-open window; an empty or inverted window never asserts.
  function automatic logic in_window(input logic [VID_CW-1:0] cnt,
                                     input logic [VID_CW-1:0] lo,
                                     input logic [VID_CW-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vid_pix_fifo.sv
// Pixel FIFO with occupancy and flush; read data is the head entry (no push->pop bypass).
// Level updates one clock after push/pop; a push on full is accepted only alongside a pop.
module vid_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vid_scanout.sv
// Scanout: pixel FIFO, pixel-clock divider, h/v counters and sync/blank decode; outputs register one clock after each tick.
// No backpressure to fetch: pushes into a full FIFO are dropped and flagged, pops on empty drive black and flag underflow.
module vid_scanout
  import vid_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [5:0]                    pcnt,
  input  logic [12:0]                   hsize,
  input  logic [12:0]                   hend,
  input  logic [12:0]                   hsync_start,
  input  logic [12:0]                   hsync_end,
  input  logic [12:0]                   vsize,
  input  logic [12:0]                   vend,
  input  logic [12:0]                   vsync_start,
  input  logic [12:0]                   vsync_end,
  input  logic                          pix_wr,
  input  logic [31:0]                   pix_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          line_start,
  output logic                          frame_start,
  input  logic                          clr_err,
  output logic                          underflow,
  output logic                          overflow,
  output logic                          hsync,
  output logic                          hblank,
  output logic                          vsync,
  output logic                          vblank,
  output logic [7:0]                    R,
  output logic [7:0]                    G,
  output logic [7:0]                    B
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_THR = LW'(PRIME_LVL);
  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_PRIME = 2'(ST_PRIME);
  localparam logic [1:0] S_RUN   = 2'(ST_RUN);

  cr_t cr;
  h1_t h1;
  h2_t h2;
  v1_t v1;
  v2_t v2;

  assign cr = '{pcnt: pcnt, en: en};
  assign h1 = '{hend: hend, hsize: hsize};
  assign h2 = '{hsync_end: hsync_end, hsync_start: hsync_start};
  assign v1 = '{vend: vend, vsize: vsize};
  assign v2 = '{vsync_end: vsync_end, vsync_start: vsync_start};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [5:0]        div;
  logic [VID_CW-1:0] hcnt;
  logic [VID_CW-1:0] vcnt;
  logic              flush;
  logic              prime_ok;
  logic              start_pulse;
  logic              tick;
  logic              h_wrap;
  logic              v_wrap;
  logic              hblank_c;
  logic              vblank_c;
  logic              hsync_c;
  logic              vsync_c;
  logic              active;
  logic              pop;
  logic              uflow_set;
  logic              oflow_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [23:0]       fifo_rdata;
  logic              unused_hi;

  assign unused_hi = ^pix_wdata[31:24];

  assign flush       = !cr.en;
  assign prime_ok    = (fifo_level >= PRIME_THR);
  assign start_pulse = cr.en && (state == S_PRIME) && prime_ok;
  // Gated by en so the cycle in which en drops cannot pop or flag.
  assign tick        = cr.en && (state == S_RUN) && (div == cr.pcnt);
  assign h_wrap      = (hcnt == h1.hend);
  assign v_wrap      = (vcnt == v1.vend);

  assign hblank_c = (hcnt >= h1.hsize);
  assign vblank_c = (vcnt >= v1.vsize);
  assign hsync_c  = in_window(hcnt, h2.hsync_start, h2.hsync_end);
  assign vsync_c  = in_window(vcnt, v2.vsync_start, v2.vsync_end);

  assign active    = tick && !hblank_c && !vblank_c;
  assign pop       = active && !fifo_empty;
  assign uflow_set = active && fifo_empty;
  assign oflow_set = cr.en && pix_wr && fifo_full && !pop;

  vid_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (pix_wr),
    .wdata (pix_wdata[23:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    if (!cr.en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_PRIME;
        S_PRIME: if (prime_ok) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Held at 0 outside RUN so the first RUN cycle always starts a fresh pixel period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (state != S_RUN || div == cr.pcnt) begin
      div <= '0;
    end else begin
      div <= div + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!cr.en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + VID_CW'(1);
      end else begin
        hcnt <= hcnt + VID_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b0;
      hblank      <= 1'b0;
      vsync       <= 1'b0;
      vblank      <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else if (!cr.en) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b0;
      hblank      <= 1'b0;
      vsync       <= 1'b0;
      vblank      <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else begin
      line_start  <= start_pulse || (tick && h_wrap);
      frame_start <= start_pulse || (tick && h_wrap && v_wrap);
      if (tick) begin
        hsync  <= hsync_c;
        hblank <= hblank_c;
        vsync  <= vsync_c;
        vblank <= vblank_c;
        R      <= pop ? fifo_rdata[23:16] : 8'd0;
        G      <= pop ? fifo_rdata[15:8]  : 8'd0;
        B      <= pop ? fifo_rdata[7:0]   : 8'd0;
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (uflow_set)    underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
      if (oflow_set)    overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_scanout.sv
// Bench for vid_scanout: directed scenarios plus randomized traffic checked every cycle against a tick-indexed reference model.
module tb_vid_scanout;

  localparam int DEPTH = 16;
  localparam int PRIME = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  pcnt = '0;
  logic [12:0] hsize = '0, hend = '0, hsync_start = '0, hsync_end = '0;
  logic [12:0] vsize = '0, vend = '0, vsync_start = '0, vsync_end = '0;
  logic        pix_wr = 1'b0;
  logic [31:0] pix_wdata = '0;
  logic        clr_err = 1'b0;
  logic [4:0]  fifo_level;
  logic        line_start, frame_start, underflow, overflow;
  logic        hsync, hblank, vsync, vblank;
  logic [7:0]  R, G, B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vid_scanout #(.FIFO_DEPTH(DEPTH), .PRIME_LVL(PRIME)) dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
    .hsize(hsize), .hend(hend), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vsize(vsize), .vend(vend), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .pix_wr(pix_wr), .pix_wdata(pix_wdata), .fifo_level(fifo_level),
    .line_start(line_start), .frame_start(frame_start), .clr_err(clr_err),
    .underflow(underflow), .overflow(overflow),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B)
  );

  // Reference model: phase 0 idle, 1 priming, 2 running; run_n counts clocks since RUN began.
  int          phase;
  int          run_n;
  logic [23:0] q[$];
  logic        e_hs, e_hb, e_vs, e_vb, e_ls, e_fs, e_uf, e_of;
  logic [23:0] e_rgb;

  function automatic logic [36:0] obs();
    return {hsync, hblank, vsync, vblank, line_start, frame_start, underflow, overflow, R, G, B, fifo_level};
  endfunction

  function automatic logic [36:0] exp_v();
    return {e_hs, e_hb, e_vs, e_vb, e_ls, e_fs, e_uf, e_of, e_rgb, 5'(q.size())};
  endfunction

  task automatic model_reset();
    phase = 0; run_n = 0; q.delete();
    {e_hs, e_hb, e_vs, e_vb, e_ls, e_fs, e_uf, e_of} = '0;
    e_rgb = '0;
  endtask

  task automatic model_step();
    int p, k, h, v, pre_lvl;
    logic uf_set, of_set;
    pre_lvl = q.size();
    uf_set = 1'b0; of_set = 1'b0;
    e_ls = 1'b0; e_fs = 1'b0;
    if (!en) begin
      phase = 0; q.delete();
      {e_hs, e_hb, e_vs, e_vb} = '0;
      e_rgb = '0;
    end else begin
      if (phase == 2) begin
        p = int'(pcnt);
        if (run_n % (p + 1) == p) begin
          k = run_n / (p + 1);
          h = k % (int'(hend) + 1);
          v = (k / (int'(hend) + 1)) % (int'(vend) + 1);
          e_hb = (h >= int'(hsize));
          e_vb = (v >= int'(vsize));
          e_hs = (h >= int'(hsync_start)) && (h < int'(hsync_end));
          e_vs = (v >= int'(vsync_start)) && (v < int'(vsync_end));
          e_ls = (h == int'(hend));
          e_fs = (h == int'(hend)) && (v == int'(vend));
          e_rgb = '0;
          if (!e_hb && !e_vb) begin
            if (q.size() > 0) e_rgb = q.pop_front();
            else uf_set = 1'b1;
          end
        end
        run_n++;
      end else if (phase == 1) begin
        if (pre_lvl >= PRIME) begin
          phase = 2; run_n = 0; e_ls = 1'b1; e_fs = 1'b1;
        end
      end else begin
        phase = 1;
      end
      if (pix_wr) begin
        if (q.size() < DEPTH) q.push_back(pix_wdata[23:0]);
        else of_set = 1'b1;
      end
    end
    e_uf = uf_set ? 1'b1 : (clr_err ? 1'b0 : e_uf);
    e_of = of_set ? 1'b1 : (clr_err ? 1'b0 : e_of);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_timing(input int p, input int hs, input int he, input int hss, input int hse,
                            input int vs, input int ve, input int vss, input int vse);
    en = 1'b0; pix_wr = 1'b0; clr_err = 1'b0;
    pcnt = 6'(p);
    hsize = 13'(hs); hend = 13'(he); hsync_start = 13'(hss); hsync_end = 13'(hse);
    vsize = 13'(vs); vend = 13'(ve); vsync_start = 13'(vss); vsync_end = 13'(vse);
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (obs() !== 37'd0) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs(), 37'd0);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (obs() !== exp_v()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_basic();
    int fs_last;
    logic [7:0] cb;
    fs_last = -1;
    set_timing(0, 4, 7, 5, 6, 2, 3, 3, 4);
    en = 1'b1;
    for (int c = 0; c < 110; c++) begin
      cb = 8'(c);
      pix_wr = (c < 8);
      pix_wdata = {8'($urandom), cb, cb, cb};
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (frame_start === 1'b1) begin
        if (fs_last >= 0) begin
          checks++;
          if (c - fs_last != 32) begin
            errors++; $display("FAIL basic_frame_period got=%0d exp=32", c - fs_last);
          end
        end
        fs_last = c;
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_divider();
    int ls_last;
    ls_last = -1;
    set_timing(2, 4, 7, 5, 6, 2, 3, 3, 4);
    en = 1'b1;
    for (int c = 0; c < 120; c++) begin
      pix_wr = (c % 3 == 0);
      pix_wdata = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL divider c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (line_start === 1'b1) begin
        if (ls_last >= 0) begin
          checks++;
          if (c - ls_last != 24) begin
            errors++; $display("FAIL divider_line_period got=%0d exp=24", c - ls_last);
          end
        end
        ls_last = c;
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_underflow();
    set_timing(0, 8, 9, 8, 9, 4, 5, 4, 5);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      pix_wr = (c < 4);
      pix_wdata = $urandom;
      clr_err = (c == 50);
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL underflow c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (c == 12) begin
        checks++;
        if (underflow !== 1'b1 || {R, G, B} !== 24'd0) begin
          errors++; $display("FAIL underflow_set got=%b rgb=%h exp=1 rgb=0", underflow, {R, G, B});
        end
      end
      if (c == 52) begin
        checks++;
        if (underflow !== 1'b0) begin
          errors++; $display("FAIL underflow_clear got=%b exp=0", underflow);
        end
      end
    end
    clr_err = 1'b0;
  endtask

  task automatic test_push_pop_empty();
    set_timing(0, 8, 9, 8, 9, 4, 5, 4, 5);
    en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      pix_wr = (c < 4) || (c >= 10);
      pix_wdata = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL push_pop_empty c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (c == 10) begin
        checks++;
        if (fifo_level !== 5'd1 || underflow !== 1'b1 || {R, G, B} !== 24'd0) begin
          errors++; $display("FAIL push_pop_empty_boundary level=%0d uf=%b rgb=%h exp level=1 uf=1 rgb=0",
                             fifo_level, underflow, {R, G, B});
        end
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_overflow();
    set_timing(0, 0, 3, 0, 0, 0, 1, 0, 0);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      pix_wr = (c < 17);
      pix_wdata = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL overflow c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (c == 17) begin
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
          errors++; $display("FAIL overflow_drop level=%0d of=%b exp level=16 of=1", fifo_level, overflow);
        end
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] cb;
    set_timing(63, 8, 9, 0, 0, 2, 2, 0, 0);
    en = 1'b1;
    for (int c = 0; c < 140; c++) begin
      cb = 8'(c);
      pix_wr = 1'b1;
      pix_wdata = {8'hEE, cb, cb ^ 8'h55, cb + 8'd1};
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL full_pop c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (c == 68) begin
        checks++;
        if (fifo_level !== 5'd16 || {R, G, B} !== 24'h005501) begin
          errors++; $display("FAIL full_pop_accept level=%0d rgb=%h exp level=16 rgb=005501", fifo_level, {R, G, B});
        end
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_disable_midframe();
    set_timing(0, 4, 7, 5, 6, 2, 3, 3, 4);
    for (int c = 0; c < 50; c++) begin
      en = !(c == 20 || c == 21);
      pix_wr = (c < 8) || c == 22 || c == 23 || c == 24 || c == 27;
      pix_wdata = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL disable c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
      if (c == 20) begin
        checks++;
        if ({hsync, hblank, vsync, vblank, line_start, frame_start, R, G, B, fifo_level} !== 35'd0) begin
          errors++; $display("FAIL disable_clear got=%h exp=0",
                             {hsync, hblank, vsync, vblank, line_start, frame_start, R, G, B, fifo_level});
        end
      end
      if (c == 27 || c == 28) begin
        checks++;
        if (frame_start !== (c == 28) || line_start !== (c == 28)) begin
          errors++; $display("FAIL disable_restart c=%0d fs=%b ls=%b exp=%b", c, frame_start, line_start, c == 28);
        end
      end
    end
    pix_wr = 1'b0;
  endtask

  task automatic test_reset_midframe();
    set_timing(0, 4, 7, 5, 6, 2, 3, 3, 4);
    en = 1'b1;
    for (int c = 0; c < 15; c++) begin
      pix_wr = (c < 10);
      pix_wdata = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL reset_mid_run c=%0d got=%h exp=%h", c, obs(), exp_v());
      end
    end
    pix_wr = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== 37'd0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", obs());
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    cycle();
    checks++;
    if (obs() !== exp_v()) begin
      errors++; $display("FAIL reset_mid_release got=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_random();
    int he, ve, prob;
    for (int it = 0; it < 8; it++) begin
      he = $urandom_range(2, 9);
      ve = $urandom_range(1, 5);
      set_timing($urandom_range(0, 3), $urandom_range(0, he + 1), he,
                 $urandom_range(0, he + 1), $urandom_range(0, he + 1),
                 $urandom_range(0, ve + 1), ve,
                 $urandom_range(0, ve + 1), $urandom_range(0, ve + 1));
      prob = $urandom_range(20, 90);
      for (int c = 0; c < 300; c++) begin
        en = ($urandom_range(0, 199) != 0);
        pix_wr = ($urandom_range(0, 99) < prob);
        pix_wdata = $urandom;
        clr_err = ($urandom_range(0, 19) == 0);
        cycle();
        checks++;
        if (obs() !== exp_v()) begin
          errors++; $display("FAIL random it=%0d c=%0d got=%h exp=%h", it, c, obs(), exp_v());
        end
      end
    end
    pix_wr = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_underflow();
    test_push_pop_empty();
    test_overflow();
    test_full_pop();
    test_disable_midframe();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
